// File: rtl/multi_channel_burst_generator.sv
// ---------------------------------------------------------------------------
// multi_channel_burst_generator
//
// Shared-timing tone-burst sequencer. One phase engine (HIGH / LOW / GAP)
// drives NUM_CH square-wave outputs; each channel has its own enable and
// polarity. All timing and channel settings are captured into shadow
// registers when a sequence starts, so the register bank can be rewritten
// while a sequence runs without disturbing it.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       global enable; low forces IDLE
//   start        begin a sequence (only honoured in IDLE)
//   abort        terminate the current sequence (no done pulse)
//   high_cycles  HIGH phase length in cycles, 0 behaves as 1
//   low_cycles   LOW phase length in cycles, 0 behaves as 1
//   pulse_count  pulses per burst, 0 behaves as 1
//   burst_count  bursts per sequence, 0 = run continuously
//   gap_cycles   idle gap between bursts, 0 = no gap
//   ch_enable    per-channel pulse enable
//   ch_invert    per-channel output polarity
//   tone_out     registered tone outputs
//   busy         registered, high whenever state is not IDLE
//   done         one-cycle pulse on natural completion
//   pulse_idx    0-based pulse index inside the current burst
//   burst_idx    0-based burst index (wraps in continuous mode)
//   state_out    IDLE=0, HIGH=1, LOW=2, GAP=3
// ---------------------------------------------------------------------------
module multi_channel_burst_generator #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  high_cycles,
  input  logic [CNT_W-1:0]  low_cycles,
  input  logic [CNT_W-1:0]  pulse_count,
  input  logic [CNT_W-1:0]  burst_count,
  input  logic [CNT_W-1:0]  gap_cycles,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] ch_invert,
  output logic [NUM_CH-1:0] tone_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pulse_idx,
  output logic [CNT_W-1:0]  burst_idx,
  output logic [1:0]        state_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);

  // State, counters and registered outputs
  state_t             r_state;
  logic [CNT_W-1:0]   r_phase_cnt;
  logic [CNT_W-1:0]   r_pulse_idx;
  logic [CNT_W-1:0]   r_burst_idx;
  logic [NUM_CH-1:0]  r_tone;
  logic               r_busy;
  logic               r_done;

  // Shadow copies captured at start
  logic [CNT_W-1:0]   r_high_s;
  logic [CNT_W-1:0]   r_low_s;
  logic [CNT_W-1:0]   r_pulse_s;
  logic [CNT_W-1:0]   r_burst_s;
  logic [CNT_W-1:0]   r_gap_s;
  logic [NUM_CH-1:0]  r_ch_en_s;
  logic [NUM_CH-1:0]  r_ch_inv_s;

  // Next-state signals
  state_t             w_next_state;
  logic [CNT_W-1:0]   w_next_phase;
  logic [CNT_W-1:0]   w_next_pulse;
  logic [CNT_W-1:0]   w_next_burst;
  logic               w_load;
  logic               w_done_next;
  logic [NUM_CH-1:0]  w_en_sel;
  logic [NUM_CH-1:0]  w_inv_sel;
  logic [NUM_CH-1:0]  w_tone_next;

  // Effective (zero-clamped) lengths and end-of-pulse/burst conditions
  logic [CNT_W-1:0]   w_high_eff;
  logic [CNT_W-1:0]   w_low_eff;
  logic [CNT_W-1:0]   w_pulse_eff;
  logic               w_last_pulse;
  logic               w_last_burst;

  assign w_high_eff   = (r_high_s  == ZERO) ? ONE : r_high_s;
  assign w_low_eff    = (r_low_s   == ZERO) ? ONE : r_low_s;
  assign w_pulse_eff  = (r_pulse_s == ZERO) ? ONE : r_pulse_s;
  assign w_last_pulse = (r_pulse_idx == (w_pulse_eff - ONE));
  // burst_count of zero means continuous: never the last burst
  assign w_last_burst = (r_burst_s != ZERO) && (r_burst_idx == (r_burst_s - ONE));

  // Next-state and counter logic; phase counter counts 1..N and compares with ==
  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase_cnt;
    w_next_pulse = r_pulse_idx;
    w_next_burst = r_burst_idx;
    w_load       = 1'b0;
    w_done_next  = 1'b0;

    if (abort || !enable) begin
      w_next_state = S_IDLE;
      w_next_phase = ONE;
      w_next_pulse = ZERO;
      w_next_burst = ZERO;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_load       = 1'b1;
            w_next_state = S_HIGH;
            w_next_phase = ONE;
            w_next_pulse = ZERO;
            w_next_burst = ZERO;
          end
        end

        S_HIGH: begin
          if (r_phase_cnt == w_high_eff) begin
            w_next_state = S_LOW;
            w_next_phase = ONE;
          end else begin
            w_next_phase = r_phase_cnt + ONE;
          end
        end

        S_LOW: begin
          if (r_phase_cnt == w_low_eff) begin
            w_next_phase = ONE;
            if (!w_last_pulse) begin
              w_next_state = S_HIGH;
              w_next_pulse = r_pulse_idx + ONE;
            end else if (!w_last_burst) begin
              // Burst index wraps naturally in continuous mode
              w_next_state = (r_gap_s == ZERO) ? S_HIGH : S_GAP;
              w_next_pulse = ZERO;
              w_next_burst = r_burst_idx + ONE;
            end else begin
              // No trailing gap after the final burst
              w_next_state = S_IDLE;
              w_next_pulse = ZERO;
              w_next_burst = ZERO;
              w_done_next  = 1'b1;
            end
          end else begin
            w_next_phase = r_phase_cnt + ONE;
          end
        end

        S_GAP: begin
          if (r_phase_cnt == r_gap_s) begin
            w_next_state = S_HIGH;
            w_next_phase = ONE;
          end else begin
            w_next_phase = r_phase_cnt + ONE;
          end
        end

        default: begin
          w_next_state = S_IDLE;
          w_next_phase = ONE;
          w_next_pulse = ZERO;
          w_next_burst = ZERO;
        end
      endcase
    end
  end

  // Channel settings seen by the next cycle: fresh inputs on the start edge
  assign w_en_sel    = w_load ? ch_enable : r_ch_en_s;
  assign w_inv_sel   = w_load ? ch_invert : r_ch_inv_s;
  assign w_tone_next = (w_next_state == S_HIGH) ? (w_en_sel ^ w_inv_sel) : w_inv_sel;

  // State register, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= ONE;
      r_pulse_idx <= ZERO;
      r_burst_idx <= ZERO;
      r_tone      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_phase_cnt <= w_next_phase;
      r_pulse_idx <= w_next_pulse;
      r_burst_idx <= w_next_burst;
      r_tone      <= w_tone_next;
      r_busy      <= (w_next_state != S_IDLE);
      r_done      <= w_done_next;
    end
  end

  // Shadow registers, loaded only when a sequence is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_s   <= ZERO;
      r_low_s    <= ZERO;
      r_pulse_s  <= ZERO;
      r_burst_s  <= ZERO;
      r_gap_s    <= ZERO;
      r_ch_en_s  <= '0;
      r_ch_inv_s <= '0;
    end else if (w_load) begin
      r_high_s   <= high_cycles;
      r_low_s    <= low_cycles;
      r_pulse_s  <= pulse_count;
      r_burst_s  <= burst_count;
      r_gap_s    <= gap_cycles;
      r_ch_en_s  <= ch_enable;
      r_ch_inv_s <= ch_invert;
    end
  end

  assign tone_out  = r_tone;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_idx = r_pulse_idx;
  assign burst_idx = r_burst_idx;
  assign state_out = r_state;

endmodule

// File: tb/tb_multi_channel_burst_generator.sv
// ---------------------------------------------------------------------------
// tb_multi_channel_burst_generator
//
// Directed bench for multi_channel_burst_generator. Inputs are driven and
// outputs sampled on the falling edge; "cycle k" is the k-th falling edge
// after the rising edge that sampled start.
// ---------------------------------------------------------------------------
module tb_multi_channel_burst_generator;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  high_cycles;
  logic [CNT_W-1:0]  low_cycles;
  logic [CNT_W-1:0]  pulse_count;
  logic [CNT_W-1:0]  burst_count;
  logic [CNT_W-1:0]  gap_cycles;
  logic [NUM_CH-1:0] ch_enable;
  logic [NUM_CH-1:0] ch_invert;
  logic [NUM_CH-1:0] tone_out;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  pulse_idx;
  logic [CNT_W-1:0]  burst_idx;
  logic [1:0]        state_out;

  int n_vec  = 0;
  int n_fail = 0;

  multi_channel_burst_generator #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .start       (start),
    .abort       (abort),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .pulse_count (pulse_count),
    .burst_count (burst_count),
    .gap_cycles  (gap_cycles),
    .ch_enable   (ch_enable),
    .ch_invert   (ch_invert),
    .tone_out    (tone_out),
    .busy        (busy),
    .done        (done),
    .pulse_idx   (pulse_idx),
    .burst_idx   (burst_idx),
    .state_out   (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int h, input int l, input int p, input int b, input int g,
                     input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] inv);
    high_cycles = CNT_W'(h);
    low_cycles  = CNT_W'(l);
    pulse_count = CNT_W'(p);
    burst_count = CNT_W'(b);
    gap_cycles  = CNT_W'(g);
    ch_enable   = en;
    ch_invert   = inv;
  endtask

  // Pulse start for one edge; returns at cycle 1 of the new sequence
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic [NUM_CH-1:0] idle_tone);
    check({tag, "_state"}, 64'(state_out), 64'd0);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_done"},  64'(done),      64'd0);
    check({tag, "_tone"},  64'(tone_out),  64'(idle_tone));
    check({tag, "_pidx"},  64'(pulse_idx), 64'd0);
    check({tag, "_bidx"},  64'(burst_idx), 64'd0);
  endtask

  initial begin : stim
    logic exp_b;
    logic saw_done;

    rst_n  = 1'b0;
    enable = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    cfg(2, 3, 2, 2, 4, 4'b0001, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    check_idle("reset", 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic train: H=2 L=3 P=2 B=2 G=4
    do_start();
    for (int k = 1; k <= 26; k++) begin
      exp_b = (k >= 1 && k <= 2) || (k >= 6 && k <= 7) ||
              (k >= 15 && k <= 16) || (k >= 20 && k <= 21);
      check($sformatf("basic_tone_k%0d", k), 64'(tone_out), 64'(exp_b));
      check($sformatf("basic_busy_k%0d", k), 64'(busy), 64'(k <= 24));
      check($sformatf("basic_done_k%0d", k), 64'(done), 64'(k == 25));
      if (k == 1)  check("basic_st_k1",  64'(state_out), 64'd1);
      if (k == 3)  check("basic_st_k3",  64'(state_out), 64'd2);
      if (k == 6)  check("basic_pidx_k6", 64'(pulse_idx), 64'd1);
      if (k == 11) begin
        check("basic_st_k11",   64'(state_out), 64'd3);
        check("basic_pidx_k11", 64'(pulse_idx), 64'd0);
        check("basic_bidx_k11", 64'(burst_idx), 64'd1);
      end
      if (k == 20) begin
        check("basic_pidx_k20", 64'(pulse_idx), 64'd1);
        check("basic_bidx_k20", 64'(burst_idx), 64'd1);
      end
      if (k == 25) check("basic_st_k25", 64'(state_out), 64'd0);
      @(negedge clk);
    end

    // Polarity and masking: en=0101 inv=0011, H=2 L=2 P=1 B=1
    cfg(2, 2, 1, 1, 0, 4'b0101, 4'b0011);
    do_start();
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("pol_tone_k%0d", k), 64'(tone_out),
            (k <= 2) ? 64'b0110 : 64'b0011);
      check($sformatf("pol_done_k%0d", k), 64'(done), 64'(k == 5));
      @(negedge clk);
    end
    check_idle("pol_idle", 4'b0011);

    // Zero-value edge case: everything 0 except burst_count=1
    cfg(0, 0, 0, 1, 0, 4'b0001, 4'b0000);
    do_start();
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("zero_tone_k%0d", k), 64'(tone_out), 64'(k == 1));
      check($sformatf("zero_busy_k%0d", k), 64'(busy), 64'(k <= 2));
      check($sformatf("zero_done_k%0d", k), 64'(done), 64'(k == 3));
      if (k == 2) check("zero_st_k2", 64'(state_out), 64'd2);
      @(negedge clk);
    end

    // Continuous mode, then abort during HIGH
    cfg(1, 1, 2, 0, 0, 4'b0001, 4'b0000);
    do_start();
    saw_done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      saw_done = saw_done | done;
      @(negedge clk);
    end
    check("cont_no_done", 64'(saw_done), 64'd0);
    check("cont_st_k41",   64'(state_out), 64'd1);
    check("cont_bidx_k41", 64'(burst_idx), 64'd10);
    check("cont_pidx_k41", 64'(pulse_idx), 64'd0);
    check("cont_tone_k41", 64'(tone_out),  64'b0001);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort", 4'b0000);

    // Same again, dropping enable instead of abort
    do_start();
    for (int k = 1; k <= 4; k++) @(negedge clk);
    check("en_st_k5",   64'(state_out), 64'd1);
    check("en_bidx_k5", 64'(burst_idx), 64'd1);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    check_idle("endrop", 4'b0000);

    // Shadow latching and ignored second start
    cfg(3, 2, 2, 1, 0, 4'b0001, 4'b0000);
    do_start();
    high_cycles = CNT_W'(1);
    start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) start = 1'b0;
      check($sformatf("shadow_tone_k%0d", k), 64'(tone_out),
            64'((k <= 3) || (k >= 6 && k <= 8)));
      check($sformatf("shadow_done_k%0d", k), 64'(done), 64'(k == 11));
      @(negedge clk);
    end
    check_idle("shadow_end", 4'b0000);

    // start together with abort in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_idle("start_abort", 4'b0000);

    // Asynchronous reset in the middle of LOW
    cfg(2, 5, 1, 1, 0, 4'b0101, 4'b0011);
    do_start();
    for (int k = 1; k <= 3; k++) @(negedge clk);
    check("rst_pre_st", 64'(state_out), 64'd2);
    rst_n = 1'b0;
    #1;
    check_idle("async_rst", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Restart after reset, then back-to-back start in the done cycle
    do_start();
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("rs_tone_k%0d", k), 64'(tone_out),
            (k <= 2) ? 64'b0110 : 64'b0011);
      @(negedge clk);
    end
    check("rs_done_k8",  64'(done),      64'd1);
    check("rs_busy_k8",  64'(busy),      64'd0);
    check("rs_st_k8",    64'(state_out), 64'd0);
    do_start();
    check("b2b_st_k1",   64'(state_out), 64'd1);
    check("b2b_busy_k1", 64'(busy),      64'd1);
    check("b2b_done_k1", 64'(done),      64'd0);
    check("b2b_tone_k1", 64'(tone_out),  64'b0110);
    for (int k = 1; k <= 7; k++) @(negedge clk);
    check("b2b_done_k8", 64'(done), 64'd1);
    @(negedge clk);
    check("b2b_done_k9", 64'(done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_channel_burst_generator.md
# multi_channel_burst_generator

Multi-channel, parametrised tone-burst sequencer: one shared timing engine drives NUM_CH square-wave outputs with per-channel enable and polarity. It takes high and low times directly in clock cycles, so it needs no duty-cycle multiplier. All parameters are latched into shadow registers at start, so register writes mid-sequence have no effect. It sits between the register bank and the transducer drivers, and supports finite or continuous burst trains, abort, and a completion pulse.

## Interface
- NUM_CH, 4: number of tone outputs (1..32)
- CNT_W, 16: width of all timing and count fields and counters

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  global enable; low forces IDLE
- start  in  1  begin sequence (sampled in IDLE only)
- abort  in  1  terminate sequence
- high_cycles  in  CNT_W  HIGH phase length in cycles (0 treated as 1)
- low_cycles  in  CNT_W  LOW phase length in cycles (0 treated as 1)
- pulse_count  in  CNT_W  pulses per burst (0 treated as 1)
- burst_count  in  CNT_W  bursts per sequence; 0 = continuous
- gap_cycles  in  CNT_W  inter-burst gap in cycles; 0 = no gap
- ch_enable  in  NUM_CH  per-channel pulse enable
- ch_invert  in  NUM_CH  per-channel output polarity
- tone_out  out  NUM_CH  registered tone outputs
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on natural completion
- pulse_idx  out  CNT_W  current pulse in burst, 0-based
- burst_idx  out  CNT_W  current burst, 0-based
- state_out  out  2  IDLE=0, HIGH=1, LOW=2, GAP=3

## Operation
- Start: in IDLE with enable=1, start=1, abort=0, all inputs are captured into shadow registers and the next state is HIGH. A start issued while busy, or with enable=0, is ignored.
- HIGH: lasts max(high_cycles,1) cycles, then goes to LOW.
- LOW: lasts max(low_cycles,1) cycles, then branches:
  - If this is not the last pulse of the burst, go to HIGH and increment pulse_idx.
  - Else, if this is not the last burst, go to GAP (or straight to HIGH when gap_cycles=0). Clear pulse_idx and increment burst_idx.
  - Else, go to IDLE and pulse done. There is no trailing gap.
- GAP: lasts gap_cycles cycles, then goes to HIGH.
- Continuous mode (burst_count=0): the sequence never completes. burst_idx wraps modulo 2^CNT_W.
- Abort: abort=1 or enable=0 in any state forces IDLE on the next edge. Counters and indices clear, and done is not asserted. When start and abort are both high in IDLE, abort wins.
- tone_out[i] in HIGH = ch_en_s[i] ^ ch_inv_s[i]. In every other state tone_out[i] = ch_inv_s[i]. The _s suffix denotes the shadow value.
- Disabled channels therefore hold their idle polarity throughout the sequence.
- Width rules:
  - Phase and gap counters compare against shadow values with ==, counting from 1.
  - Indices are CNT_W bits wide.
  - An all-ones count is legal and does not overflow.

## Timing
- Reset values: tone_out=0, busy=0, done=0, pulse_idx=0, burst_idx=0, state_out=0, all shadows=0.
- Start sampled at edge T: state_out=HIGH, busy=1 and tone_out active from cycle T+1.
- tone_out, busy and state_out change on the same edge. They are registered and carry no combinational path from the inputs.
- Each pulse occupies H+L cycles. Each burst occupies P·(H+L) cycles. The sequence lasts B·P·(H+L) + (B−1)·G cycles.
- done is high for exactly one cycle, the first IDLE cycle after completion, coincident with busy falling.
- A new start is accepted in that same done cycle; the next sequence begins one cycle later.
- Abort sampled at edge A: idle levels and busy=0 from cycle A+1.
- Reset assertion mid-sequence asynchronously returns all outputs to their reset values.
- Input changes while busy have no effect until the next start.

## Test plan
- Basic train, with H=2, L=3, P=2, B=2, G=4, ch_enable=0001, start at T:
  - tone_out[0] is high at T+1..2, T+6..7, T+15..16 and T+20..21.
  - tone_out[0] is low in all other cycles.
  - done is asserted at T+25; busy is high T+1..T+24.
- Polarity and masking, with ch_enable=0101, ch_invert=0011:
  - Idle outputs are 0011.
  - During HIGH, outputs are 0110.
  - Channel 1 stays at 1 throughout; channel 3 stays at 0.
- Zero-value edge cases, with high_cycles=0, low_cycles=0, pulse_count=0, burst_count=1, gap=0:
  - Exactly one pulse: HIGH for 1 cycle, LOW for 1 cycle.
  - done is asserted at T+3.
- Continuous mode and abort, with burst_count=0, gap=0:
  - No done pulse is ever asserted.
  - Abort during HIGH returns outputs to idle, busy=0 and indices 0 on the next cycle, with no done pulse.
  - Repeating the check with enable dropped instead of abort gives the same result.
- Shadow latching and ignored start:
  - Changing high_cycles mid-sequence does not change pulse width.
  - A second start while busy is ignored.
  - start=1 with abort=1 in IDLE stays in IDLE.
- Async reset and restart:
  - Asserting rst_n low mid-LOW clears all outputs immediately.
  - After release, start works normally.
  - Start in the done cycle produces back-to-back sequences separated by one IDLE cycle.
